// File: rtl/cnn_relu_pkg.sv
// Shared fp32 helpers for the ReLU forward/backward layers.
// The leaky path (fp32_scale_pow2_down) is used when RELU_LEAKY_EN is defined.
package cnn_relu_pkg;

    typedef logic [31:0] fp32_t;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;

    // +0, -0 and anything with the sign bit set are not positive.
    function automatic logic fp32_is_pos(fp32_t x);
        return ~x[FP_SIGN_BIT] & (|x[FP_EXP_MSB:0]);
    endfunction

    // Multiply by 2^-sh through the exponent field only. Results that would
    // underflow flush to a signed zero; zeros and denormals flush to +0.
    // NaN and Inf pass through unchanged.
    function automatic fp32_t fp32_scale_pow2_down(fp32_t x, int sh);
        logic [7:0] e;
        int         ed;
        fp32_t      r;
        e  = x[FP_EXP_MSB:FP_EXP_LSB];
        ed = int'({24'd0, e}) - sh;
        if (e == 8'hFF)
            r = x;
        else if (e == 8'h00)
            r = '0;
        else if (ed <= 0)
            r = {x[FP_SIGN_BIT], 31'd0};
        else
            r = {x[FP_SIGN_BIT], 8'(ed), x[FP_EXP_LSB-1:0]};
        return r;
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// Mask FIFO with registered storage; head entry is visible without a pop
// (first-word-fall-through). Pointers wrap naturally at power-of-two DEPTH.
module relu_mask_fifo #(
    parameter int DW    = 40,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/relu_forward_mask_layer.sv
// Forward ReLU over WIDTH fp32 lanes with a one-deep output register and a
// positivity-mask FIFO for the backward stage. Define RELU_LEAKY_EN for leaky slope.
module relu_forward_mask_layer
    import cnn_relu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int NEG_SHIFT = 4,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            id,
    input  logic [WIDTH-1:0][31:0] in_vec,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0][31:0] out_vec,
    output logic [31:0]            out_id,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   mask_pop,
    output logic [WIDTH-1:0]       mask,
    output logic [31:0]            mask_id,
    output logic                   mask_valid,
    output logic [CW-1:0]          mask_count
);

    logic [WIDTH-1:0]       pos;
    logic [WIDTH-1:0][31:0] lane_out;
    logic [WIDTH-1:0][31:0] out_vec_q, out_vec_d;
    logic [31:0]            out_id_q, out_id_d;
    logic                   out_valid_q, out_valid_d;
    logic                   fifo_full, fifo_empty, xfer;
    logic [32+WIDTH-1:0]    fifo_rdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        assign pos[g] = fp32_is_pos(in_vec[g]);
`ifdef RELU_LEAKY_EN
        assign lane_out[g] = pos[g] ? in_vec[g] : fp32_scale_pow2_down(in_vec[g], NEG_SHIFT);
`else
        assign lane_out[g] = pos[g] ? in_vec[g] : 32'h0000_0000;
`endif
    end

    // Full comes from the registered count, so a same-cycle pop cannot open the input.
    assign in_ready = (~out_valid_q | out_ready) & ~fifo_full;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        out_vec_d   = out_vec_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_vec_d   = lane_out;
            out_id_d    = id;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_vec_q   <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_vec_q   <= out_vec_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    relu_mask_fifo #(
        .DW    (32 + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (xfer),
        .pop   (mask_pop),
        .wdata ({id, pos}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (mask_count)
    );

    assign out_vec    = out_vec_q;
    assign out_id     = out_id_q;
    assign out_valid  = out_valid_q;
    assign mask       = fifo_rdata[WIDTH-1:0];
    assign mask_id    = fifo_rdata[32+WIDTH-1:WIDTH];
    assign mask_valid = ~fifo_empty;

endmodule

// File: tb/tb_relu_forward_mask_layer.sv
// Scoreboard bench for relu_forward_mask_layer; leaky expectations apply when RELU_LEAKY_EN is defined.
module tb_relu_forward_mask_layer;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     id;
    logic [7:0][31:0] in_vec;
    logic            in_valid;
    logic            in_ready;
    logic [7:0][31:0] out_vec;
    logic [31:0]     out_id;
    logic            out_valid;
    logic            out_ready;
    logic            mask_pop;
    logic [7:0]      mask;
    logic [31:0]     mask_id;
    logic            mask_valid;
    logic [4:0]      mask_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [255:0] v; logic [31:0] id; } out_t;
    typedef struct { logic [7:0] m; logic [31:0] id; } msk_t;
    out_t exp_out[$];
    msk_t exp_msk[$];

    // Vectors written lane 7 first; expected results computed by hand.
    localparam logic [255:0] V1 = {32'hC2C80000, 32'h00000001, 32'hFF800000, 32'h7F800000,
                                   32'h80000000, 32'h00000000, 32'hBF800000, 32'h3F800000};
    localparam logic [255:0] V2 = {32'h7F800000, 32'h80000000, 32'h00000000, 32'h3F800000,
                                   32'hFFC00000, 32'h80000001, 32'h80800000, 32'hBF800000};
    localparam logic [255:0] V3 = {32'h00000000, 32'h3F000000, 32'hFFC00000, 32'h7FC00000,
                                   32'hBF000000, 32'h00800000, 32'h80000000, 32'h40490FDB};
    localparam logic [255:0] VP = {32'h40E00000, 32'h40C00000, 32'h40A00000, 32'h40800000,
                                   32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000};
    localparam logic [255:0] VQ = {32'h41000000, 32'h40F00000, 32'h40D00000, 32'h40B00000,
                                   32'h40900000, 32'h40500000, 32'h40100000, 32'h3F400000};
`ifdef RELU_LEAKY_EN
    localparam logic [255:0] E1 = {32'hC0C80000, 32'h00000001, 32'hFF800000, 32'h7F800000,
                                   32'h00000000, 32'h00000000, 32'hBD800000, 32'h3F800000};
    localparam logic [255:0] E2 = {32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                                   32'hFFC00000, 32'h00000000, 32'h80000000, 32'hBD800000};
    localparam logic [255:0] E3 = {32'h00000000, 32'h3F000000, 32'hFFC00000, 32'h7FC00000,
                                   32'hBD000000, 32'h00800000, 32'h00000000, 32'h40490FDB};
`else
    localparam logic [255:0] E1 = {32'h00000000, 32'h00000001, 32'h00000000, 32'h7F800000,
                                   32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000};
    localparam logic [255:0] E2 = {32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                                   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    localparam logic [255:0] E3 = {32'h00000000, 32'h3F000000, 32'h00000000, 32'h7FC00000,
                                   32'h00000000, 32'h00800000, 32'h00000000, 32'h40490FDB};
`endif

    relu_forward_mask_layer #(.WIDTH(8), .DEPTH(16), .NEG_SHIFT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .id         (id),
        .in_vec     (in_vec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_vec    (out_vec),
        .out_id     (out_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mask_pop   (mask_pop),
        .mask       (mask),
        .mask_id    (mask_id),
        .mask_valid (mask_valid),
        .mask_count (mask_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [255:0] v, input logic [31:0] idv);
        in_vec   = v;
        id       = idv;
        in_valid = 1'b1;
    endtask

    task automatic expect_xfer(input logic [255:0] ev, input logic [7:0] m, input logic [31:0] idv);
        out_t o;
        msk_t k;
        o.v = ev; o.id = idv;
        k.m = m;  k.id = idv;
        exp_out.push_back(o);
        exp_msk.push_back(k);
    endtask

    // Pattern alternation used by the streaming tests.
    task automatic send_alt(input int i);
        if (i % 2 == 0) begin
            set_in(V3, i); expect_xfer(E3, 8'h55, i);
        end else begin
            set_in(VP, i); expect_xfer(VP, 8'hFF, i);
        end
    endtask

    task automatic drain_masks();
        int n = 0;
        mask_pop = 1'b1;
        while (mask_count != 0 && n < 64) begin
            tick();
            n++;
        end
        mask_pop = 1'b0;
        chk("drain_count", 256'(mask_count), 256'd0);
    endtask

    // Monitor: compares each completed handshake against the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL out_unexpected got id %0d expected none", out_id);
                end else begin
                    out_t o;
                    o = exp_out.pop_front();
                    chk("out_vec", out_vec, o.v);
                    chk("out_id", 256'(out_id), 256'(o.id));
                end
            end
            if (mask_pop && mask_valid) begin
                if (exp_msk.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mask_unexpected got id %0d expected none", mask_id);
                end else begin
                    msk_t k;
                    k = exp_msk.pop_front();
                    chk("mask", 256'(mask), 256'(k.m));
                    chk("mask_id", 256'(mask_id), 256'(k.id));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; id = '0; in_vec = '0; in_valid = 1'b0;
        out_ready = 1'b1; mask_pop = 1'b0;

        // 1: reset values and basic pass-through
        tick(); tick();
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_out_vec", out_vec, 256'd0);
        chk("rst_out_id", 256'(out_id), 256'd0);
        chk("rst_mask_valid", 256'(mask_valid), 256'd0);
        chk("rst_mask", 256'(mask), 256'd0);
        chk("rst_mask_id", 256'(mask_id), 256'd0);
        chk("rst_mask_count", 256'(mask_count), 256'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        set_in(V1, 5); expect_xfer(E1, 8'b01010001, 5);
        tick();
        chk("t1_out_valid", 256'(out_valid), 256'd1);
        chk("t1_mask_valid", 256'(mask_valid), 256'd1);
        chk("t1_mask_head", 256'(mask), 256'h51);
        set_in(V2, 6); expect_xfer(E2, 8'h90, 6);
        tick();
        in_valid = 1'b0;
        drain_masks();

        // 2: backpressure
        out_ready = 1'b0;
        set_in(VP, 10); expect_xfer(VP, 8'hFF, 10);
        tick();
        chk("t2_in_ready_low", 256'(in_ready), 256'd0);
        set_in(VQ, 11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_vec", out_vec, VP);
            chk("t2_hold_id", 256'(out_id), 256'd10);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_in_ready_release", 256'(in_ready), 256'd1);
        expect_xfer(VQ, 8'hFF, 11);
        tick();
        in_valid = 1'b0;
        chk("t2_next_id", 256'(out_id), 256'd11);
        drain_masks();

        // 3: FIFO full without pops
        for (int i = 0; i < 16; i++) begin
            send_alt(100 + i);
            #1;
            chk("t3_in_ready", 256'(in_ready), 256'd1);
            tick();
        end
        set_in(VP, 116);
        #1;
        chk("t3_full_count", 256'(mask_count), 256'd16);
        chk("t3_full_ready", 256'(in_ready), 256'd0);
        mask_pop = 1'b1;
        tick();
        mask_pop = 1'b0;
        chk("t3_pop_count", 256'(mask_count), 256'd15);
        chk("t3_ready_after_pop", 256'(in_ready), 256'd1);
        expect_xfer(VP, 8'hFF, 116);
        tick();
        in_valid = 1'b0;
        chk("t3_refill_count", 256'(mask_count), 256'd16);
        drain_masks();

        // 4: pointer wrap, push and pop each cycle
        send_alt(0);
        tick();
        mask_pop = 1'b1;
        for (int i = 1; i < 40; i++) begin
            send_alt(i);
            tick();
            chk("t4_count", 256'(mask_count), 256'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("t4_empty", 256'(mask_count), 256'd0);
        tick(); tick();
        chk("t4_pop_empty", 256'(mask_count), 256'd0);
        mask_pop = 1'b0;

        // 5: reset mid-operation
        for (int i = 0; i < 7; i++) begin
            send_alt(200 + i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t5_pre_count", 256'(mask_count), 256'd7);
        chk("t5_pre_valid", 256'(out_valid), 256'd1);
        reset = 1'b0;
        exp_out.delete();
        exp_msk.delete();
        tick();
        chk("t5_count", 256'(mask_count), 256'd0);
        chk("t5_out_valid", 256'(out_valid), 256'd0);
        chk("t5_mask_valid", 256'(mask_valid), 256'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();

        chk("sb_out_empty", 256'(exp_out.size()), 256'd0);
        chk("sb_mask_empty", 256'(exp_msk.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
